// File: rtl/fht_loader_if.sv
// fht_loader_if: sample stream, FHT core write port and status signals of
// the FHT front-end loader. The loader takes the slave modport; whatever
// feeds samples and watches the core status takes the master modport.
interface fht_loader_if #(
  parameter int D_BIT   = 16,
  parameter int A_BIT   = 8,
  parameter int CNT_BIT = 16
);
  logic               iEN;
  logic               iVALID;
  logic [D_BIT-2:0]   iSAMPLE;
  logic               oREADY;
  logic               iFHT_RDY;
  logic [D_BIT-2:0]   oDATA;
  logic [A_BIT-1:0]   oADDR_WR;
  logic               oWE_0;
  logic               oWE_1;
  logic               oWE_2;
  logic               oWE_3;
  logic               oSTART;
  logic               oBUSY;
  logic               oFRAME_DONE;
  logic [CNT_BIT-1:0] oDROP_CNT;

  modport master (
    output iEN, iVALID, iSAMPLE, iFHT_RDY,
    input  oREADY, oDATA, oADDR_WR, oWE_0, oWE_1, oWE_2, oWE_3,
           oSTART, oBUSY, oFRAME_DONE, oDROP_CNT
  );

  modport slave (
    input  iEN, iVALID, iSAMPLE, iFHT_RDY,
    output oREADY, oDATA, oADDR_WR, oWE_0, oWE_1, oWE_2, oWE_3,
           oSTART, oBUSY, oFRAME_DONE, oDROP_CNT
  );
endinterface

// File: rtl/fht_loader.sv
// fht_loader: front end of the FHT core. Takes ADC samples over a
// valid/ready handshake, spreads each frame of N = 4*2^A_BIT points across
// the core's four input RAM banks, strobes the core's start input once the
// frame is complete and then waits for the core to finish before taking the
// next frame. Samples offered while the loader cannot take them are counted.
// Optional build macro: FHT_LOADER_BITREV_EN stores the frame in
// bit-reversed index order (as the in-place transform expects) instead of
// natural order.
module fht_loader #(
  parameter int D_BIT   = 16,
  parameter int A_BIT   = 8,
  parameter int CNT_BIT = 16
) (
  input  logic          iCLK,
  input  logic          iRESET,
  fht_loader_if.slave   bus
);

  localparam int IDX_BIT = A_BIT + 2;
  localparam logic [IDX_BIT-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_WAIT} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_BIT-1:0] idx;
  logic [IDX_BIT-1:0] idx_nxt;
  logic [IDX_BIT-1:0] map_idx;
  logic               accept;
  logic [D_BIT-2:0]   data_q;
  logic [A_BIT-1:0]   addr_q;
  logic [3:0]         we_q;
  logic               busy_q;
  logic               done_q;
  logic [CNT_BIT-1:0] drop_q;

  // Ready is a pure decode of the state register, so iVALID never reaches it
  assign accept = (state == S_LOAD) && bus.iVALID;

`ifdef FHT_LOADER_BITREV_EN
  // Reverse the sample index across all A_BIT+2 bits to get its RAM slot
  always_comb begin
    map_idx = '0;
    for (int i = 0; i < IDX_BIT; i++) begin
      map_idx[i] = idx[IDX_BIT-1-i];
    end
  end
`else
  assign map_idx = idx;
`endif

  // Frame sequencing: next state and next sample index
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (bus.iEN) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (accept) begin
          if (idx == LAST_IDX) begin
            state_nxt = S_START;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else if (!bus.iEN && (idx == '0)) begin
          state_nxt = S_IDLE;
        end
      end
      S_START: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.iFHT_RDY) state_nxt = bus.iEN ? S_LOAD : S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and index registers; reset abandons any partial frame
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Registered write port: one bank enable for one cycle after each accept
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      data_q <= '0;
      addr_q <= '0;
      we_q   <= '0;
    end else begin
      we_q <= '0;
      if (accept) begin
        data_q <= bus.iSAMPLE;
        addr_q <= map_idx[A_BIT+1:2];
        we_q   <= 4'b0001 << map_idx[1:0];
      end
    end
  end

  // Busy spans first accept to core completion; frame-done echoes the core
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == S_WAIT) && bus.iFHT_RDY;
      if (accept && (idx == '0)) begin
        busy_q <= 1'b1;
      end else if ((state == S_WAIT) && bus.iFHT_RDY) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Saturating count of samples offered while a frame is with the core
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      drop_q <= '0;
    end else if (bus.iVALID && ((state == S_START) || (state == S_WAIT))
                 && (drop_q != '1)) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  assign bus.oREADY      = (state == S_LOAD);
  assign bus.oSTART      = (state == S_START);
  assign bus.oDATA       = data_q;
  assign bus.oADDR_WR    = addr_q;
  assign bus.oWE_0       = we_q[0];
  assign bus.oWE_1       = we_q[1];
  assign bus.oWE_2       = we_q[2];
  assign bus.oWE_3       = we_q[3];
  assign bus.oBUSY       = busy_q;
  assign bus.oFRAME_DONE = done_q;
  assign bus.oDROP_CNT   = drop_q;

endmodule
